// File: rtl/dsp_dot_seq_pkg.sv
// Shared types and constants for the dot-product sequencer and the DSP slice it drives.
package dsp_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_CAPTURE,
    S_DONE
  } seq_state_t;

  localparam logic [2:0] DSP_MODE_ADD = 3'b001;
  localparam logic [2:0] DSP_MODE_MUL = 3'b010;
  localparam logic [2:0] DSP_MODE_MAC = 3'b100;

  localparam int unsigned CLEAR_CYCLES = 2;
  localparam int unsigned DRAIN_CYCLES = 2;
  localparam int unsigned PHASE_W      = 2;

endpackage

// File: rtl/dsp_dot_seq_if.sv
// Operand stream and result handshake between a vector source/consumer and the sequencer.
interface dsp_dot_seq_if #(
  parameter int unsigned DWIDTH = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] in_a;
  logic [DWIDTH-1:0] in_b;
  logic              res_valid;
  logic              res_ready;
  logic [DWIDTH-1:0] res_data;

  modport master (
    output in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, res_data
  );
endinterface

// File: rtl/dsp_slice.sv
// Signed DSP slice: add / saturating multiply / saturating MAC with wrapping accumulator.
module dsp_slice
  import dsp_seq_pkg::*;
#(
  parameter int unsigned DWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] a_in,
  input  logic [DWIDTH-1:0] b_in,
  input  logic              carry_in,
  input  logic [2:0]        mode,
  output logic [DWIDTH-1:0] c_out
);

  localparam logic signed [2*DWIDTH-1:0] PMAX = {{(DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [2*DWIDTH-1:0] PMIN = {{(DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

  logic signed [2*DWIDTH-1:0] prod;
  logic [DWIDTH-1:0]          stage;
  logic [DWIDTH-1:0]          p_q;
  logic [DWIDTH-1:0]          acc;
  logic [2:0]                 mode_q;

  always_comb begin
    prod  = $signed(a_in) * $signed(b_in);
    stage = '0;
    case (mode)
      DSP_MODE_ADD: stage = a_in + b_in + {{(DWIDTH-1){1'b0}}, carry_in};
      DSP_MODE_MUL, DSP_MODE_MAC: begin
        if (prod > PMAX)      stage = PMAX[DWIDTH-1:0];
        else if (prod < PMIN) stage = PMIN[DWIDTH-1:0];
        else                  stage = prod[DWIDTH-1:0];
      end
      default: stage = '0;
    endcase
  end

  // Product register then accumulator; the caller's registered operands form the first stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q    <= '0;
      mode_q <= DSP_MODE_ADD;
      acc    <= '0;
    end else begin
      p_q    <= stage;
      mode_q <= mode;
      acc    <= (mode_q == DSP_MODE_MAC) ? acc + p_q : p_q;
    end
  end

  assign c_out = acc;

endmodule

// File: rtl/dsp_dot_seq.sv
// Sequences one dsp_slice through clear / MAC / drain / capture to produce a signed dot product.
module dsp_dot_seq
  import dsp_seq_pkg::*;
#(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  dsp_dot_seq_if.slave      stream,
  output logic [DWIDTH-1:0] dsp_a_in,
  output logic [DWIDTH-1:0] dsp_b_in,
  output logic              dsp_carry_in,
  output logic [2:0]        dsp_mode,
  input  logic [DWIDTH-1:0] dsp_c_out
);

  seq_state_t         state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt;
  logic [PHASE_W-1:0] phase;
  logic [DWIDTH-1:0]  res_data_q;
  logic               res_valid_q;

  assign stream.in_ready  = (state == S_RUN);
  assign stream.res_valid = res_valid_q;
  assign stream.res_data  = res_data_q;
  assign dsp_carry_in     = 1'b0;

  // Outputs are assigned for the state being entered, so they are valid in that state's cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      len_q       <= '0;
      cnt         <= '0;
      phase       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      busy        <= 1'b0;
      dsp_mode    <= DSP_MODE_ADD;
      dsp_a_in    <= '0;
      dsp_b_in    <= '0;
    end else begin
      dsp_a_in <= '0;
      dsp_b_in <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q    <= len;
            cnt      <= '0;
            phase    <= '0;
            busy     <= 1'b1;
            dsp_mode <= DSP_MODE_ADD;
            state    <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (phase == PHASE_W'(CLEAR_CYCLES - 1)) begin
            phase    <= '0;
            dsp_mode <= DSP_MODE_MAC;
            state    <= (len_q == '0) ? S_DRAIN : S_RUN;
          end else begin
            phase <= phase + PHASE_W'(1);
          end
        end
        S_RUN: begin
          if (stream.in_valid) begin
            dsp_a_in <= stream.in_a;
            dsp_b_in <= stream.in_b;
            cnt      <= cnt + LEN_W'(1);
            if (cnt == len_q - LEN_W'(1)) begin
              phase <= '0;
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (phase == PHASE_W'(DRAIN_CYCLES - 1)) begin
            phase <= '0;
            state <= S_CAPTURE;
          end else begin
            phase <= phase + PHASE_W'(1);
          end
        end
        S_CAPTURE: begin
          res_data_q  <= dsp_c_out;
          res_valid_q <= 1'b1;
          dsp_mode    <= DSP_MODE_ADD;
          state       <= S_DONE;
        end
        S_DONE: begin
          if (stream.res_ready) begin
            res_valid_q <= 1'b0;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
